// File: rtl/branch_resolver.sv
// Execute-stage branch resolver: turns ALU ZCNV flags plus funct3 into a taken
// decision, a registered fetch redirect and a fixed-length IF/ID flush.
module branch_resolver #(
    parameter int FLUSH_CYCLES = 2,
    parameter int COUNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               br_valid,
    output logic               br_ready,
    input  logic               is_jump,
    input  logic [2:0]         funct3,
    input  logic [3:0]         flags,
    input  logic [31:0]        target,
    output logic               redirect_valid,
    output logic [31:0]        redirect_pc,
    output logic               flush,
    output logic               misalign,
    output logic               illegal_br,
    output logic [COUNT_W-1:0] taken_count
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

    state_t               state_q, state_d;
    logic [3:0]           flush_cnt_q, flush_cnt_d;
    logic                 redirect_valid_q, redirect_valid_d;
    logic [31:0]          redirect_pc_q, redirect_pc_d;
    logic                 flush_q, flush_d;
    logic                 misalign_q, misalign_d;
    logic                 illegal_br_q, illegal_br_d;
    logic [COUNT_W-1:0]   taken_count_q, taken_count_d;

    logic                 cond_s;
    logic                 illegal_s;
    logic [31:0]          eff_target_s;
    logic                 flag_z, flag_c, flag_n, flag_v;

    assign flag_z       = flags[3];
    assign flag_c       = flags[2];
    assign flag_n       = flags[1];
    assign flag_v       = flags[0];
    assign eff_target_s = target & ~32'h0000_0001;

    // Branch condition decode; C=1 means rs1 >= rs2 unsigned
    always_comb begin
        cond_s    = 1'b0;
        illegal_s = 1'b0;
        if (is_jump) begin
            cond_s = 1'b1;
        end else begin
            case (funct3)
                3'b000:         cond_s = flag_z;
                3'b001:         cond_s = ~flag_z;
                3'b100:         cond_s = flag_n ^ flag_v;
                3'b101:         cond_s = ~(flag_n ^ flag_v);
                3'b110:         cond_s = ~flag_c;
                3'b111:         cond_s = flag_c;
                3'b010, 3'b011: illegal_s = 1'b1;
                default:        cond_s = 1'b0;
            endcase
        end
    end

    // Next-state and registered-output computation
    always_comb begin
        state_d          = state_q;
        flush_cnt_d      = flush_cnt_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        misalign_d       = 1'b0;
        illegal_br_d     = 1'b0;
        taken_count_d    = taken_count_q;
        case (state_q)
            ST_IDLE: begin
                if (br_valid) begin
                    illegal_br_d = illegal_s;
                    if (cond_s && eff_target_s[1]) begin
                        misalign_d = 1'b1;
                    end else if (cond_s) begin
                        redirect_valid_d = 1'b1;
                        redirect_pc_d    = eff_target_s;
                        taken_count_d    = taken_count_q + COUNT_W'(1'b1);
                        state_d          = ST_FLUSH;
                        flush_cnt_d      = FLUSH_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                // Last flush cycle when the counter has run down to one
                if (flush_cnt_q <= 4'd1) begin
                    state_d     = ST_IDLE;
                    flush_cnt_d = 4'd0;
                end else begin
                    flush_cnt_d = flush_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                flush_cnt_d = 4'd0;
            end
        endcase
        flush_d = (state_d == ST_FLUSH);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            flush_cnt_q      <= 4'd0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'h0000_0000;
            flush_q          <= 1'b0;
            misalign_q       <= 1'b0;
            illegal_br_q     <= 1'b0;
            taken_count_q    <= '0;
        end else begin
            state_q          <= state_d;
            flush_cnt_q      <= flush_cnt_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            flush_q          <= flush_d;
            misalign_q       <= misalign_d;
            illegal_br_q     <= illegal_br_d;
            taken_count_q    <= taken_count_d;
        end
    end

    assign br_ready       = (state_q == ST_IDLE);
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign flush          = flush_q;
    assign misalign       = misalign_q;
    assign illegal_br     = illegal_br_q;
    assign taken_count    = taken_count_q;

endmodule
